// File: rtl/conv_pkg.sv
// Shared encodings and sizes for the CONV memory-side responder.
package conv_pkg;

  localparam int unsigned DW       = 20;
  localparam int unsigned AW       = 12;
  localparam int unsigned L1_DEPTH = 1024;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int unsigned ERR_CSEL = 0;
  localparam int unsigned ERR_RW   = 1;
  localparam int unsigned ERR_TMO  = 2;
  localparam int unsigned ERR_IMG  = 3;

  // Cycles allowed in WAIT_BUSY before busy must have risen.
  localparam int unsigned WAIT_LIMIT = 16;

  typedef enum logic [2:0] {IDLE, KICK, WAIT_BUSY, RUN, DONE} state_t;

endpackage

// File: rtl/conv_sram_2r1w.sv
// Single-write store with one combinational and one registered read port.
module conv_sram_2r1w #(
  parameter  int unsigned DEPTH = 4096,
  parameter  int unsigned WIDTH = 20,
  localparam int unsigned ABITS = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [ABITS-1:0] raddr_q,
  output logic [WIDTH-1:0] rdata_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem[raddr_q];
  end

endmodule

// File: rtl/conv_mem_host.sv
// CONV memory responder: image/L0/L1 stores, run sequencing and host port.
module conv_mem_host
  import conv_pkg::*;
#(
  parameter  int unsigned DW       = conv_pkg::DW,
  parameter  int unsigned AW       = conv_pkg::AW,
  parameter  int unsigned L1_DEPTH = conv_pkg::L1_DEPTH,
  parameter  logic [19:0] TIMEOUT  = 20'd600000,
  localparam int unsigned L1_AW    = $clog2(L1_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            img_we,
  input  logic [AW-1:0]   img_addr,
  input  logic [DW-1:0]   img_wdata,
  input  logic            rb_sel,
  input  logic [AW-1:0]   rb_addr,
  output logic [DW-1:0]   rb_data,
  output logic            ready,
  input  logic            busy,
  input  logic [AW-1:0]   iaddr,
  output logic [DW-1:0]   idata,
  input  logic            cwr,
  input  logic [AW-1:0]   caddr_wr,
  input  logic [DW-1:0]   cdata_wr,
  input  logic            crd,
  input  logic [AW-1:0]   caddr_rd,
  output logic [DW-1:0]   cdata_rd,
  input  logic [2:0]      csel,
  output logic            done,
  output logic [AW:0]     l0_wr_cnt,
  output logic [L1_AW:0]  l1_wr_cnt,
  output logic [3:0]      err
);

  localparam logic [AW:0]    L0_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [L1_AW:0] L1_MAX = {1'b1, {L1_AW{1'b0}}};

  state_t        state, state_nx;
  logic          busy_q, tmo_hit, rb_sel_q;
  logic          host_ok, img_wr, l0_we, l1_we;
  logic [19:0]   cyc_cnt;
  logic [3:0]    err_set;
  logic [DW-1:0] l0_rd, l1_rd, l0_rq, l1_rq, img_rq_unused;

  assign host_ok = (state == IDLE) || (state == DONE);
  assign img_wr  = img_we && host_ok;
  assign l0_we   = cwr && (csel == CSEL_L0);
  assign l1_we   = cwr && (csel == CSEL_L1);

  conv_sram_2r1w #(.DEPTH(1 << AW), .WIDTH(DW)) u_img (
    .clk(clk), .reset(reset), .we(img_wr), .waddr(img_addr), .wdata(img_wdata),
    .raddr(iaddr), .rdata(idata), .raddr_q('0), .rdata_q(img_rq_unused)
  );

  conv_sram_2r1w #(.DEPTH(1 << AW), .WIDTH(DW)) u_l0 (
    .clk(clk), .reset(reset), .we(l0_we), .waddr(caddr_wr), .wdata(cdata_wr),
    .raddr(caddr_rd), .rdata(l0_rd), .raddr_q(rb_addr), .rdata_q(l0_rq)
  );

  conv_sram_2r1w #(.DEPTH(L1_DEPTH), .WIDTH(DW)) u_l1 (
    .clk(clk), .reset(reset), .we(l1_we), .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
    .raddr(caddr_rd[L1_AW-1:0]), .rdata(l1_rd), .raddr_q(rb_addr[L1_AW-1:0]), .rdata_q(l1_rq)
  );

  // Both banks are read every cycle; the registered select picks one.
  assign rb_data = rb_sel_q ? l1_rq : l0_rq;

  always_comb begin
    cdata_rd = '0;
    case (csel)
      CSEL_L0:   cdata_rd = l0_rd;
      CSEL_L1:   cdata_rd = l1_rd;
      CSEL_NONE: cdata_rd = '0;
      default:   cdata_rd = '0;
    endcase
  end

  always_comb begin
    err_set           = '0;
    err_set[ERR_CSEL] = (cwr || crd) && !(csel == CSEL_L0 || csel == CSEL_L1);
    err_set[ERR_RW]   = cwr && crd;
    err_set[ERR_TMO]  = tmo_hit;
    err_set[ERR_IMG]  = img_we && !host_ok;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE:      if (start) state_nx = KICK;
      KICK: begin
        ready    = 1'b1;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) state_nx = RUN;
        else if (cyc_cnt == 20'(WAIT_LIMIT - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = DONE;
        end
      end
      RUN: begin
        if (busy_q && !busy) state_nx = DONE;
        else if (cyc_cnt == TIMEOUT - 20'd1) begin
          tmo_hit  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = KICK;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      rb_sel_q  <= 1'b0;
      cyc_cnt   <= '0;
      err       <= '0;
      l0_wr_cnt <= '0;
      l1_wr_cnt <= '0;
    end else begin
      state    <= state_nx;
      busy_q   <= busy;
      rb_sel_q <= rb_sel;
      // Restarts on every state change so WAIT_BUSY and RUN each time from zero.
      cyc_cnt  <= (state_nx != state) ? '0 : cyc_cnt + 20'd1;
      if (state == KICK) begin
        err       <= '0;
        l0_wr_cnt <= '0;
        l1_wr_cnt <= '0;
      end else begin
        err <= err | err_set;
        if (l0_we && (l0_wr_cnt != L0_MAX)) l0_wr_cnt <= l0_wr_cnt + {{AW{1'b0}}, 1'b1};
        if (l1_we && (l1_wr_cnt != L1_MAX)) l1_wr_cnt <= l1_wr_cnt + {{L1_AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host with an array-level store model and a CONV stub.
module tb_conv_mem_host;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, img_we = 1'b0, rb_sel = 1'b0;
  logic        busy = 1'b0, cwr = 1'b0, crd = 1'b0;
  logic [11:0] img_addr = '0, rb_addr = '0, iaddr = '0, caddr_wr = '0, caddr_rd = '0;
  logic [19:0] img_wdata = '0, cdata_wr = '0;
  logic [2:0]  csel = '0;
  logic [19:0] rb_data, idata, cdata_rd;
  logic        ready, done;
  logic [12:0] l0_wr_cnt;
  logic [10:0] l1_wr_cnt;
  logic [3:0]  err;

  int checks = 0, errors = 0;

  conv_mem_host dut (
    .clk(clk), .reset(reset), .start(start), .img_we(img_we), .img_addr(img_addr),
    .img_wdata(img_wdata), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .done(done), .l0_wr_cnt(l0_wr_cnt),
    .l1_wr_cnt(l1_wr_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pix(input int unsigned i);
    logic [31:0] v;
    if (i == 32'h41) return 20'h01000;
    v = (i * 32'h9E37) ^ (i << 9);
    return v[19:0];
  endfunction

  function automatic logic [19:0] relu(input logic [19:0] v);
    return v[19] ? 20'h0 : v;
  endfunction

  function automatic logic [19:0] pool(input int unsigned k);
    int unsigned r, c;
    logic [19:0] m, v;
    r = k / 32;
    c = k % 32;
    m = '0;
    for (int unsigned dr = 0; dr < 2; dr++)
      for (int unsigned dc = 0; dc < 2; dc++) begin
        v = relu(pix((2 * r + dr) * 64 + 2 * c + dc));
        if (v > m) m = v;
      end
    return m;
  endfunction

  // Store model: what each array holds, plus counters and error bits.
  bit [19:0] m_img [4096], m_l0 [4096], m_l1 [1024];
  bit        m_img_v [4096], m_l0_v [4096], m_l1_v [1024];
  bit [19:0] m_rb = '0;
  bit        m_rb_v = 1'b1;
  int        m_l0c = 0, m_l1c = 0;
  bit [3:0]  m_err = '0;
  bit        host_ok = 1'b1;
  int        kick_tok = 0, kick_seen = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rb = '0; m_rb_v = 1'b1; m_l0c = 0; m_l1c = 0; m_err = '0; kick_seen = kick_tok;
    end else begin
      if (rb_sel) begin m_rb = m_l1[rb_addr[9:0]]; m_rb_v = m_l1_v[rb_addr[9:0]]; end
      else        begin m_rb = m_l0[rb_addr];      m_rb_v = m_l0_v[rb_addr];      end
      if (kick_tok != kick_seen) begin
        kick_seen = kick_tok; m_l0c = 0; m_l1c = 0; m_err = '0;
      end else begin
        if ((cwr || crd) && csel != 3'b001 && csel != 3'b011) m_err[0] = 1'b1;
        if (cwr && crd) m_err[1] = 1'b1;
        if (img_we && !host_ok) m_err[3] = 1'b1;
        if (cwr && csel == 3'b001 && m_l0c < 4096) m_l0c++;
        if (cwr && csel == 3'b011 && m_l1c < 1024) m_l1c++;
      end
      if (cwr && csel == 3'b001) begin m_l0[caddr_wr] = cdata_wr; m_l0_v[caddr_wr] = 1'b1; end
      if (cwr && csel == 3'b011) begin m_l1[caddr_wr[9:0]] = cdata_wr; m_l1_v[caddr_wr[9:0]] = 1'b1; end
      if (img_we && host_ok) begin m_img[img_addr] = img_wdata; m_img_v[img_addr] = 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (m_img_v[iaddr]) chk("idata", idata, m_img[iaddr]);
    if (csel == 3'b001) begin
      if (m_l0_v[caddr_rd]) chk("cdata_rd_l0", cdata_rd, m_l0[caddr_rd]);
    end else if (csel == 3'b011) begin
      if (m_l1_v[caddr_rd[9:0]]) chk("cdata_rd_l1", cdata_rd, m_l1[caddr_rd[9:0]]);
    end else chk("cdata_rd_none", cdata_rd, 0);
    if (m_rb_v) chk("rb_data", rb_data, m_rb);
    chk("l0_wr_cnt", l0_wr_cnt, m_l0c);
    chk("l1_wr_cnt", l1_wr_cnt, m_l1c);
    chk("err_bits", {err[3], err[1:0]}, {m_err[3], m_err[1:0]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    kick_tok++;
    host_ok = 1'b0;
    chk("ready_pulse", ready, 1);
    tick();
    chk("ready_one_cycle", ready, 0);
    chk("err_cleared", err, 0);
    chk("l0_cnt_cleared", l0_wr_cnt, 0);
    chk("l1_cnt_cleared", l1_wr_cnt, 0);
  endtask

  initial begin
    logic [19:0] mx;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_rb_data", rb_data, 0);
    chk("rst_l0_cnt", l0_wr_cnt, 0);
    chk("rst_l1_cnt", l1_wr_cnt, 0);
    chk("rst_err", err, 0);
    tick();
    reset = 1'b0;

    for (int unsigned i = 0; i < 4096; i++) begin
      img_we = 1'b1; img_addr = 12'(i); img_wdata = pix(i);
      tick();
    end
    img_we = 1'b0;
    iaddr = 12'h041;
    #1 chk("idata_041", idata, 20'h01000);

    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h0FF; cdata_wr = 20'h12345;
    tick();
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h0FF; rb_sel = 1'b0; rb_addr = 12'h0FF;
    #1 chk("l0_read_0ff", cdata_rd, 20'h12345);
    chk("l0_cnt_one", l0_wr_cnt, 1);
    tick();
    chk("rb_l0_0ff", rb_data, 20'h12345);
    crd = 1'b0; cwr = 1'b1; cdata_wr = 20'h0ABCD;
    tick();
    chk("rb_old_on_write", rb_data, 20'h12345);
    cwr = 1'b0;
    tick();
    chk("rb_new_after_write", rb_data, 20'h0ABCD);
    cwr = 1'b1; crd = 1'b1; cdata_wr = 20'h00777;
    #1 chk("rd_pre_write", cdata_rd, 20'h0ABCD);
    tick();
    chk("err_rw", err, 4'b0010);
    cwr = 1'b0;
    #1 chk("rd_post_write", cdata_rd, 20'h00777);
    chk("l0_cnt_three", l0_wr_cnt, 3);

    crd = 1'b0; cwr = 1'b1; csel = 3'b011; caddr_wr = 12'hC05; cdata_wr = 20'h54321;
    tick();
    chk("l1_cnt_one", l1_wr_cnt, 1);
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h005; rb_sel = 1'b1; rb_addr = 12'h005;
    #1 chk("l1_read_005", cdata_rd, 20'h54321);
    tick();
    chk("rb_l1_005", rb_data, 20'h54321);
    crd = 1'b0; cwr = 1'b1; csel = 3'b010; caddr_wr = 12'h005; cdata_wr = 20'hFFFFF;
    #1 chk("bad_csel_rd_zero", cdata_rd, 0);
    tick();
    chk("err_csel", err, 4'b0011);
    chk("bad_csel_l0_cnt", l0_wr_cnt, 3);
    chk("bad_csel_l1_cnt", l1_wr_cnt, 1);
    cwr = 1'b0; csel = 3'b011; crd = 1'b1; caddr_rd = 12'h005;
    #1 chk("bad_csel_no_write", cdata_rd, 20'h54321);
    crd = 1'b0; csel = 3'b000;

    // Run with a host image write while busy: dropped and flagged.
    do_start();
    busy = 1'b1;
    tick();
    img_we = 1'b1; img_addr = 12'h041; img_wdata = 20'hDEAD0; iaddr = 12'h041;
    tick();
    img_we = 1'b0;
    chk("err_img_busy", err, 4'b1000);
    chk("img_unchanged", idata, 20'h01000);
    busy = 1'b0;
    tick();
    chk("done_short_run", done, 1);
    host_ok = 1'b1;

    // Full run: CONV stub produces ReLU(image) into L0 and 2x2 maxpool into L1.
    do_start();
    busy = 1'b1;
    tick();
    for (int unsigned i = 0; i < 4096; i++) begin
      crd = 1'b0; csel = 3'b001; iaddr = 12'(i);
      #1;
      cwr = 1'b1; caddr_wr = 12'(i); cdata_wr = relu(idata);
      tick();
    end
    for (int unsigned k = 0; k < 1024; k++) begin
      mx = '0;
      for (int unsigned q = 0; q < 4; q++) begin
        cwr = 1'b0; crd = 1'b1; csel = 3'b001;
        caddr_rd = 12'((2 * (k / 32) + q / 2) * 64 + 2 * (k % 32) + q % 2);
        #1;
        if (cdata_rd > mx) mx = cdata_rd;
        tick();
      end
      crd = 1'b0; cwr = 1'b1; csel = 3'b011; caddr_wr = 12'(k); cdata_wr = mx;
      tick();
    end
    cwr = 1'b0; csel = 3'b000; busy = 1'b0;
    #1 chk("done_not_yet", done, 0);
    tick();
    chk("done_after_busy_fall", done, 1);
    host_ok = 1'b1;
    chk("run_l0_cnt", l0_wr_cnt, 4096);
    chk("run_l1_cnt", l1_wr_cnt, 1024);
    chk("run_err", err, 0);

    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h000; cdata_wr = relu(pix(0));
    tick();
    chk("l0_cnt_saturate", l0_wr_cnt, 4096);
    csel = 3'b011; cdata_wr = pool(0);
    tick();
    chk("l1_cnt_saturate", l1_wr_cnt, 1024);
    cwr = 1'b0; csel = 3'b000;

    rb_sel = 1'b0;
    for (int unsigned i = 0; i < 4096; i++) begin
      rb_addr = 12'(i);
      tick();
      chk("golden_l0", rb_data, relu(pix(i)));
    end
    rb_sel = 1'b1;
    for (int unsigned k = 0; k < 1024; k++) begin
      rb_addr = 12'(k);
      tick();
      chk("golden_l1", rb_data, pool(k));
    end

    // busy never rises: 16 cycles in WAIT_BUSY then timeout.
    do_start();
    for (int unsigned n = 2; n <= 16; n++) begin
      tick();
      chk("wait_not_done", done, 0);
    end
    tick();
    chk("wait_timeout_done", done, 1);
    chk("wait_timeout_err", err, 4'b0100);
    host_ok = 1'b1;

    // Restart from DONE, then reset in the middle of RUN.
    do_start();
    busy = 1'b1;
    tick();
    cwr = 1'b1; crd = 1'b1; csel = 3'b000;
    tick();
    chk("err_before_reset", err, 4'b0011);
    cwr = 1'b0; crd = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrun_rst_ready", ready, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_err", err, 0);
    busy = 1'b0;
    tick();
    reset = 1'b0;
    host_ok = 1'b1;
    for (int unsigned n = 0; n < 3; n++) begin
      tick();
      chk("idle_after_reset_done", done, 0);
      chk("idle_after_reset_ready", ready, 0);
    end
    rb_sel = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      rb_addr = 12'(i * 61);
      tick();
      chk("l0_kept_after_reset", rb_data, relu(pix(i * 61)));
    end
    rb_sel = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      rb_addr = 12'(k * 63);
      tick();
      chk("l1_kept_after_reset", rb_data, pool(k * 63));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
